// File: rtl/msx_slot_initiator.sv
// msx_slot_initiator
//   Host-side MSX cartridge slot bus initiator. Turns single-beat read/write
//   requests into timed slot cycles (setup / strobe / hold), stretches the
//   strobe while the cartridge holds SLT_WAITn low (with a timeout), issues
//   slot reset pulses, and generates a free-running slot clock.
// Ports
//   SYS_CLOCK, SYS_RESETn        : system clock, synchronous active-low reset
//   REQ_VALID/READY/WRITE/ADDR/WDATA : request handshake from the controller
//   CMD_SLOTRST                  : slot reset command, honoured only when idle
//   RSP_VALID/RDATA/ERR          : one-cycle completion pulse, read data, timeout
//   SLT_CLOCK, SLT_RSTn          : slot clock and slot reset
//   SLT_SLTSL, SLT_RDn, SLT_WEn  : slot select and strobes (active low)
//   SLT_A, SLT_DO, SLT_DOE, SLT_DI : address, data out/enable, data in
//   SLT_WAITn                    : cartridge wait request (async, synchronised)
module msx_slot_initiator #(
  parameter int CLK_HALF   = 2,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int WAIT_MAX   = 64,
  parameter int RST_CYC    = 16
) (
  input  logic        SYS_CLOCK,
  input  logic        SYS_RESETn,
  input  logic        REQ_VALID,
  input  logic        REQ_WRITE,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        REQ_READY,
  input  logic        CMD_SLOTRST,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_ERR,
  output logic        SLT_CLOCK,
  output logic        SLT_RSTn,
  output logic        SLT_SLTSL,
  output logic        SLT_RDn,
  output logic        SLT_WEn,
  output logic [15:0] SLT_A,
  output logic [7:0]  SLT_DO,
  output logic        SLT_DOE,
  input  logic [7:0]  SLT_DI,
  input  logic        SLT_WAITn
);

  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, SRST} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   ext_q, ext_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic            slt_clk_q, slt_clk_d;
  logic [15:0]     addr_q, addr_d;
  logic            write_q, write_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            up_q;              // 0 while in reset, 1 from the first edge after release
  logic            wait_s1_q, wait_s2_q;
  logic            base_done;

  // state register and all datapath flops
  always_ff @(posedge SYS_CLOCK) begin
    if (!SYS_RESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ext_q     <= '0;
      clk_cnt_q <= '0;
      slt_clk_q <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      up_q      <= 1'b0;
      wait_s1_q <= 1'b1;
      wait_s2_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ext_q     <= ext_d;
      clk_cnt_q <= clk_cnt_d;
      slt_clk_q <= slt_clk_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      up_q      <= 1'b1;
      wait_s1_q <= SLT_WAITn;
      wait_s2_q <= wait_s1_q;
    end
  end

  // slot clock runs regardless of the bus FSM
  always_comb begin
    clk_cnt_d = clk_cnt_q + CW'(1);
    slt_clk_d = slt_clk_q;
    if (clk_cnt_q == CW'(CLK_HALF - 1)) begin
      clk_cnt_d = '0;
      slt_clk_d = ~slt_clk_q;
    end
  end

  // strobe counter saturates at the last base cycle; extension is tracked in ext_q
  assign base_done = (cnt_q == CW'(STROBE_CYC - 1));

  // next-state / datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (up_q && CMD_SLOTRST) begin
          state_d = SRST;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
        end else if (up_q && REQ_VALID) begin
          state_d = SETUP;
          cnt_d   = '0;
          ext_d   = '0;
          addr_d  = REQ_ADDR;
          write_d = REQ_WRITE;
          wdata_d = REQ_WDATA;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STROBE: begin
        if (!base_done) begin
          cnt_d = cnt_q + CW'(1);
        end else if (wait_s2_q || ext_q == CW'(WAIT_MAX)) begin
          // leaving the strobe: error only if the cartridge still asks to wait
          state_d = HOLD;
          cnt_d   = '0;
          err_d   = ~wait_s2_q;
          if (!write_q) rdata_d = SLT_DI;
        end else begin
          ext_d = ext_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      SRST: begin
        if (cnt_q == CW'(RST_CYC - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    SLT_SLTSL = 1'b1;
    SLT_RDn   = 1'b1;
    SLT_WEn   = 1'b1;
    SLT_DOE   = 1'b0;
    SLT_RSTn  = up_q;
    case (state_q)
      IDLE:   REQ_READY = up_q & ~CMD_SLOTRST;
      SETUP,
      HOLD: begin
        SLT_SLTSL = 1'b0;
        SLT_DOE   = write_q;
      end
      STROBE: begin
        SLT_SLTSL = 1'b0;
        SLT_DOE   = write_q;
        SLT_RDn   = write_q;
        SLT_WEn   = ~write_q;
      end
      DONE:   RSP_VALID = 1'b1;
      SRST:   SLT_RSTn  = 1'b0;
      default: ;
    endcase
  end

  assign SLT_CLOCK = slt_clk_q;
  assign SLT_A     = addr_q;
  assign SLT_DO    = wdata_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_msx_slot_initiator.sv
// tb_msx_slot_initiator
//   Directed bench for msx_slot_initiator. Stimulus pushes the expected
//   response (data, error, completion cycle) into a scoreboard queue; a
//   negedge monitor pops on every RSP_VALID and compares. The monitor also
//   plays a small cartridge (bank register at 6000h, read data from address)
//   and measures strobe / select / reset pulse widths.
module tb_msx_slot_initiator;

  logic        SYS_CLOCK = 1'b0;
  logic        SYS_RESETn;
  logic        REQ_VALID, REQ_WRITE, REQ_READY, CMD_SLOTRST;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        RSP_VALID, RSP_ERR;
  logic [7:0]  RSP_RDATA;
  logic        SLT_CLOCK, SLT_RSTn, SLT_SLTSL, SLT_RDn, SLT_WEn, SLT_DOE, SLT_WAITn;
  logic [15:0] SLT_A;
  logic [7:0]  SLT_DO, SLT_DI;

  msx_slot_initiator dut (
    .SYS_CLOCK(SYS_CLOCK), .SYS_RESETn(SYS_RESETn),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_READY(REQ_READY), .CMD_SLOTRST(CMD_SLOTRST),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .SLT_CLOCK(SLT_CLOCK), .SLT_RSTn(SLT_RSTn), .SLT_SLTSL(SLT_SLTSL),
    .SLT_RDn(SLT_RDn), .SLT_WEn(SLT_WEn), .SLT_A(SLT_A), .SLT_DO(SLT_DO),
    .SLT_DOE(SLT_DOE), .SLT_DI(SLT_DI), .SLT_WAITn(SLT_WAITn)
  );

  always #5 SYS_CLOCK = ~SYS_CLOCK;

  // cartridge read data: A000h returns 3Ch, everything else addr[7:0]^5Ah
  assign SLT_DI = (SLT_A == 16'hA000) ? 8'h3C : (SLT_A[7:0] ^ 8'h5A);

  typedef struct { logic [7:0] rdata; logic err; int due; } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int rsp_cnt = 0;
  int viol = 0;
  int we_run = 0, rd_run = 0, sel_run = 0, rst_run = 0;
  int last_we = 0, last_rd = 0, last_sel = 0, last_rst = 0;
  logic we_clk0 = 1'b0, we_clk1 = 1'b0;
  logic [7:0] bank_reg = 8'h00;

  always @(posedge SYS_CLOCK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard monitor + cartridge model + pulse measurement
  always @(negedge SYS_CLOCK) begin
    exp_t e;
    if (RSP_VALID) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", int'(RSP_RDATA), int'(e.rdata));
        chk("rsp_err", int'(RSP_ERR), int'(e.err));
        chk("rsp_cycle", cyc, e.due);
      end
    end
    if (!SLT_WEn && !SLT_SLTSL && SLT_A == 16'h6000) bank_reg = SLT_DO;
    if (!SLT_WEn && !SLT_RDn) viol++;
    if (SLT_DOE && !SLT_RDn) viol++;
    if (!SLT_WEn) begin
      if (we_run == 0) begin we_clk0 = 1'b0; we_clk1 = 1'b0; end
      we_run++;
      if (SLT_CLOCK) we_clk1 = 1'b1; else we_clk0 = 1'b1;
    end else if (we_run > 0) begin last_we = we_run; we_run = 0; end
    if (!SLT_RDn) rd_run++;
    else if (rd_run > 0) begin last_rd = rd_run; rd_run = 0; end
    if (!SLT_SLTSL) sel_run++;
    else if (sel_run > 0) begin last_sel = sel_run; sel_run = 0; end
    if (!SLT_RSTn) rst_run++;
    else if (rst_run > 0) begin last_rst = rst_run; rst_run = 0; end
  end

  // drive a request and wait for its handshake; optionally queue the expectation
  task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                       input logic push, input logic [7:0] erd, input logic eerr,
                       input int lat, output int hs);
    exp_t e;
    bit ok = 1'b0;
    hs = -1;
    @(negedge SYS_CLOCK);
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_ADDR = a; REQ_WDATA = wd;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (REQ_READY) begin ok = 1'b1; break; end
      @(negedge SYS_CLOCK);
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    else begin
      hs = cyc;
      if (push) begin e.rdata = erd; e.err = eerr; e.due = cyc + lat; sb.push_back(e); end
    end
    @(posedge SYS_CLOCK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge SYS_CLOCK);
    if (sb.size() != 0) begin chk("rsp_timeout", sb.size(), 0); sb.delete(); end
    repeat (2) @(negedge SYS_CLOCK);
  endtask

  initial begin
    int hs, m, k;
    exp_t e;
    SYS_RESETn = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0;
    REQ_WDATA = '0; CMD_SLOTRST = 1'b0; SLT_WAITn = 1'b1;
    repeat (3) @(negedge SYS_CLOCK);
    // reset state
    chk("rst_clock", SLT_CLOCK, 0);
    chk("rst_rstn", SLT_RSTn, 0);
    chk("rst_sltsl", SLT_SLTSL, 1);
    chk("rst_rdn", SLT_RDn, 1);
    chk("rst_wen", SLT_WEn, 1);
    chk("rst_addr", SLT_A, 0);
    chk("rst_doe", SLT_DOE, 0);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_rspv", RSP_VALID, 0);
    chk("rst_rdata", RSP_RDATA, 0);
    SYS_RESETn = 1'b1;
    @(negedge SYS_CLOCK);
    chk("rel_rstn", SLT_RSTn, 1);
    chk("rel_ready", REQ_READY, 1);

    // write 6000h <- 05h
    issue(1'b1, 16'h6000, 8'h05, 1'b1, 8'h00, 1'b0, 9, hs);
    drain();
    chk("wr_we_len", last_we, 4);
    chk("wr_sel_len", last_sel, 8);
    chk("wr_clk_both", int'({we_clk0, we_clk1}), 3);
    chk("wr_bank", bank_reg, 8'h05);

    // read A000h
    issue(1'b0, 16'hA000, 8'hFF, 1'b1, 8'h3C, 1'b0, 9, hs);
    drain();
    chk("rd_len", last_rd, 4);
    chk("rd_addr_hold", SLT_A, 16'hA000);

    // read with WAITn low 10 cycles from strobe start: 9 extension cycles
    issue(1'b0, 16'hA000, 8'h00, 1'b1, 8'h3C, 1'b0, 18, hs);
    k = 0;
    while (SLT_RDn && k < 20) begin @(negedge SYS_CLOCK); k++; end
    chk("wait_strobe_seen", SLT_RDn, 0);
    SLT_WAITn = 1'b0;
    repeat (10) @(negedge SYS_CLOCK);
    SLT_WAITn = 1'b1;
    drain();
    chk("wait_rd_len", last_rd, 13);

    // WAITn stuck low: timeout after 4+64 strobe cycles
    SLT_WAITn = 1'b0;
    issue(1'b0, 16'h1234, 8'h00, 1'b1, 8'h6E, 1'b1, 73, hs);
    drain();
    SLT_WAITn = 1'b1;
    chk("tmo_rd_len", last_rd, 68);
    repeat (3) @(negedge SYS_CLOCK);
    issue(1'b1, 16'h6000, 8'h0A, 1'b1, 8'h00, 1'b0, 9, hs);
    drain();
    chk("tmo_next_bank", bank_reg, 8'h0A);

    // slot reset wins over a simultaneous request
    @(negedge SYS_CLOCK);
    CMD_SLOTRST = 1'b1; REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 16'h0055;
    #1;
    chk("srst_ready", REQ_READY, 0);
    m = cyc;
    e.rdata = 8'h00; e.err = 1'b0; e.due = m + 17; sb.push_back(e);
    @(posedge SYS_CLOCK); #1;
    CMD_SLOTRST = 1'b0;
    k = 0;
    @(negedge SYS_CLOCK); #1;
    while (!REQ_READY && k < 40) begin @(negedge SYS_CLOCK); #1; k++; end
    chk("srst_accept", cyc, m + 18);
    e.rdata = 8'h0F; e.err = 1'b0; e.due = cyc + 9; sb.push_back(e);
    @(posedge SYS_CLOCK); #1;
    REQ_VALID = 1'b0;
    drain();
    chk("srst_len", last_rst, 16);

    // reset during the strobe of a write
    issue(1'b1, 16'h7000, 8'h99, 1'b0, 8'h00, 1'b0, 0, hs);
    k = 0;
    while (SLT_WEn && k < 20) begin @(negedge SYS_CLOCK); k++; end
    chk("mid_strobe_seen", SLT_WEn, 0);
    k = rsp_cnt;
    SYS_RESETn = 1'b0;
    @(posedge SYS_CLOCK); #1;
    chk("mid_wen", SLT_WEn, 1);
    chk("mid_sltsl", SLT_SLTSL, 1);
    chk("mid_doe", SLT_DOE, 0);
    chk("mid_rstn", SLT_RSTn, 0);
    repeat (2) @(negedge SYS_CLOCK);
    SYS_RESETn = 1'b1;
    repeat (15) @(negedge SYS_CLOCK);
    chk("mid_no_rsp", rsp_cnt, k);
    chk("mid_after_ready", REQ_READY, 1);

    chk("invariants", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/msx_slot_initiator.md
# msx_slot_initiator

Host-side MSX cartridge slot bus initiator: turns single-beat read/write requests from an internal controller (flash programmer, cartridge dumper, bench host) into correctly timed slot cycles (SLT_A, SLT_D, SLTSL, RDn, WEn), generates the slot clock, and drives the slot reset line. It is the initiating end of the same slot protocol our cartridge bank controllers respond to. Bank-register writes, flash command sequences and ROM/MRAM reads all go through it.

## Interface
- CLK_HALF, 2: SYS_CLOCK cycles per half period of SLT_CLOCK (min 1)
- SETUP_CYC, 2: cycles address/SLTSL/data are valid before strobe (min 1)
- STROBE_CYC, 4: minimum strobe-low cycles; must be >= 2*CLK_HALF (min 1)
- HOLD_CYC, 2: cycles address/SLTSL/data are held after strobe release (min 1)
- WAIT_MAX, 64: maximum extra strobe cycles while SLT_WAITn low
- RST_CYC, 16: SLT_RSTn low duration for a slot reset command
- SYS_CLOCK  in  1  system clock, all logic on rising edge
- SYS_RESETn  in  1  synchronous, active-low reset
- REQ_VALID  in  1  request present
- REQ_WRITE  in  1  1 = write, 0 = read
- REQ_ADDR  in  16  slot address
- REQ_WDATA  in  8  write data
- REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY
- CMD_SLOTRST  in  1  slot reset command, sampled only when FSM idle
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  8  read data, valid with RSP_VALID (0 for writes)
- RSP_ERR  out  1  wait timeout, valid with RSP_VALID
- SLT_CLOCK  out  1  free-running slot clock
- SLT_RSTn  out  1  slot reset, active low
- SLT_SLTSL  out  1  slot select, active low
- SLT_RDn  out  1  read strobe, active low
- SLT_WEn  out  1  write strobe, active low
- SLT_A  out  16  slot address
- SLT_DO  out  8  slot data out
- SLT_DOE  out  1  data output enable (1 = drive SLT_DO)
- SLT_DI  in  8  slot data in
- SLT_WAITn  in  1  slot wait request, active low, registered two stages before use

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE, SRST.
- REQ_READY = (state==IDLE) & ~CMD_SLOTRST; CMD_SLOTRST wins over a simultaneous REQ_VALID (request not accepted).
- IDLE: on handshake latch ADDR/WRITE/WDATA -> SETUP. On CMD_SLOTRST -> SRST.
- SETUP: SLT_A=addr, SLTSL=0, for write SLT_DOE=1 and SLT_DO=data; count SETUP_CYC -> STROBE.
- STROBE: RDn=0 (read) or WEn=0 (write); after STROBE_CYC cycles exit if synced WAITn=1, else extend; extension counter saturating at WAIT_MAX -> set error, exit. Read: RSP_RDATA captured from SLT_DI in last strobe cycle. Exit -> HOLD.
- HOLD: strobes 1, SLT_A/SLTSL/SLT_DO/SLT_DOE unchanged; count HOLD_CYC -> DONE.
- DONE: RSP_VALID=1 one cycle, SLTSL=1, SLT_DOE=0 -> IDLE.
- SRST: SLT_RSTn=0 for RST_CYC cycles -> DONE (RSP_ERR=0, RDATA=0).
- SLT_CLOCK: counter toggles every CLK_HALF cycles, independent of FSM.
- SLT_A retains last address in IDLE; RDn and WEn never both low; SLT_DOE never 1 during a read.

## Timing
- SYS_RESETn low: state IDLE, all counters 0, SLT_CLOCK=0, SLT_RSTn=0, SLTSL=1, RDn=1, WEn=1, SLT_A=0, SLT_DO=0, SLT_DOE=0, REQ_READY=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0. SLT_RSTn goes 1 the first cycle after reset release.
- Reset mid-cycle: all outputs to reset values next edge; in-flight request dropped, no RSP_VALID.
- Handshake at cycle N: SETUP N+1..N+S, STROBE next T(+ext) cycles, HOLD next H, RSP_VALID at N+S+T+ext+H+1, REQ_READY high at N+S+T+ext+H+2. Defaults, no wait: RSP at N+9, next accept N+10.
- WAITn synchronizer adds 2-cycle latency; strobe ends no earlier than 2 cycles after WAITn rises.
- Timeout: ext reaches WAIT_MAX -> strobe released, RSP_ERR=1, RSP_RDATA=SLT_DI at last strobe cycle.
- Slot reset at N: SLT_RSTn low N+1..N+RST_CYC, RSP_VALID N+RST_CYC+1.

## Test plan
- Write 6000h/05h, defaults, responder model -> SLTSL low 8 cycles, WEn low exactly 4 cycles spanning a SLT_CLOCK rise, model bank register = 05h, RSP_VALID at N+9, RSP_ERR=0.
- Read A000h, model returns 3Ch -> RDn low 4 cycles, SLT_DOE=0 throughout, RSP_RDATA=3Ch.
- Read with WAITn low 10 cycles from strobe start -> strobe extended, RSP_VALID later by the wait-induced extension, RSP_ERR=0, data correct.
- WAITn stuck low -> strobe released after 4+64 cycles, RSP_ERR=1, next request accepted.
- CMD_SLOTRST together with REQ_VALID -> REQ_READY=0, SLT_RSTn low 16 cycles, RSP_VALID, then request accepted.
- SYS_RESETn asserted during STROBE of a write -> WEn=1, SLTSL=1, SLT_DOE=0, SLT_RSTn=0 next cycle, no RSP_VALID.
